// File: rtl/pe_pkg.sv
// Shared definitions for the row-stationary PE: FSM states, default widths
// and the signed-overflow helper used by the accumulator update.
package pe_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    MAC  = 3'd2,
    PSUM = 3'd3,
    OUT  = 3'd4
  } pe_state_e;

  localparam int unsigned PE_DATA_W_DEF      = 8;
  localparam int unsigned PE_ACC_W_DEF       = 32;
  localparam int unsigned PE_CHANNELS_DEF    = 4;
  localparam int unsigned PE_KERNEL_SIZE_DEF = 3;

  // Two's-complement add overflows when both operands share a sign that the
  // sum does not; the clip direction is then the operands' sign.
  function automatic logic add_ovf(input logic sign_a, input logic sign_b,
                                   input logic sign_s);
    return (sign_a == sign_b) && (sign_s != sign_a);
  endfunction

endpackage

// File: rtl/pe_rf.sv
// Small register file: one indexed write port, one combinational indexed
// read port, cleared by reset.
module pe_rf #(
  parameter int unsigned DEPTH  = 12,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned AW     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Storage: cleared on reset, written one entry per accepted word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < DEPTH; k++) mem_q[k] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pe_rs.sv
// Row-stationary PE: loads ifmap/weight rows into local RFs, runs a signed
// MAC over the latched length, adds an upstream psum and offers the result
// downstream with valid/ready.
// Optional feature macro: PE_SAT_EN (saturating accumulator + out_sat port).
module pe_rs
  import pe_pkg::*;
#(
  parameter int unsigned DATA_W      = PE_DATA_W_DEF,
  parameter int unsigned ACC_W       = PE_ACC_W_DEF,
  parameter int unsigned CHANNELS    = PE_CHANNELS_DEF,
  parameter int unsigned KERNEL_SIZE = PE_KERNEL_SIZE_DEF
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        start,
  input  logic [$clog2(CHANNELS*KERNEL_SIZE+1)-1:0]   cfg_len,
  input  logic                                        wht_keep,
  input  logic                                        if_vld,
  input  logic [DATA_W-1:0]                           if_data,
  output logic                                        if_rdy,
  input  logic                                        wht_vld,
  input  logic [DATA_W-1:0]                           wht_data,
  output logic                                        wht_rdy,
  input  logic                                        psum_vld,
  input  logic [ACC_W-1:0]                            psum_in,
  output logic                                        psum_rdy,
  output logic                                        out_vld,
  output logic [ACC_W-1:0]                            out_data,
`ifdef PE_SAT_EN
  output logic                                        out_sat,
`endif
  input  logic                                        out_rdy,
  output logic                                        busy
);

  localparam int unsigned RF_DEPTH = CHANNELS * KERNEL_SIZE;
  localparam int unsigned LEN_W    = $clog2(RF_DEPTH + 1);
  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(RF_DEPTH);

  pe_state_e state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              keep_q, keep_d;
  logic [LEN_W-1:0]  if_cnt_q, if_cnt_d;
  logic [LEN_W-1:0]  wt_cnt_q, wt_cnt_d;
  logic [LEN_W-1:0]  mac_cnt_q, mac_cnt_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W-1:0]  prod_q, prod_d;
  logic [ACC_W-1:0]  out_q, out_d;

  logic              if_hs, wt_hs, ps_hs;
  logic [LEN_W-1:0]  rd_idx;
  logic [DATA_W-1:0] if_rd, wt_rd;
  logic signed [2*DATA_W-1:0] mul_s;
  logic [ACC_W-1:0]  add_b, add_raw, add_res;
`ifdef PE_SAT_EN
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  logic add_clip;
  logic sat_q, sat_d;
`endif

  assign if_rdy   = (state_q == LOAD) && (if_cnt_q < len_q);
  assign wht_rdy  = (state_q == LOAD) && !keep_q && (wt_cnt_q < len_q);
  assign psum_rdy = (state_q == PSUM);
  assign out_vld  = (state_q == OUT);
  assign out_data = out_q;
  assign busy     = (state_q != IDLE);
`ifdef PE_SAT_EN
  assign out_sat  = sat_q;
`endif

  assign if_hs = if_vld & if_rdy;
  assign wt_hs = wht_vld & wht_rdy;
  assign ps_hs = psum_vld & psum_rdy;

  // The drain cycle reads past the last entry; steer it to entry 0 (unused).
  assign rd_idx = (mac_cnt_q < len_q) ? mac_cnt_q : '0;

  pe_rf #(.DEPTH(RF_DEPTH), .DATA_W(DATA_W), .AW(LEN_W)) u_if_rf (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (if_hs),
    .waddr_i (if_cnt_q),
    .wdata_i (if_data),
    .raddr_i (rd_idx),
    .rdata_o (if_rd)
  );

  pe_rf #(.DEPTH(RF_DEPTH), .DATA_W(DATA_W), .AW(LEN_W)) u_wt_rf (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (wt_hs),
    .waddr_i (wt_cnt_q),
    .wdata_i (wht_data),
    .raddr_i (rd_idx),
    .rdata_o (wt_rd)
  );

  assign mul_s = $signed(if_rd) * $signed(wt_rd);

  // Single accumulator adder shared by the MAC drain and the psum add.
  always_comb begin
    add_b   = (state_q == PSUM) ? psum_in : prod_q;
    add_raw = acc_q + add_b;
    add_res = add_raw;
`ifdef PE_SAT_EN
    add_clip = 1'b0;
    if (add_ovf(acc_q[ACC_W-1], add_b[ACC_W-1], add_raw[ACC_W-1])) begin
      add_clip = 1'b1;
      add_res  = acc_q[ACC_W-1] ? ACC_MIN : ACC_MAX;
    end
`endif
  end

  // FSM, counters and MAC pipe next-state.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    keep_d    = keep_q;
    if_cnt_d  = if_cnt_q;
    wt_cnt_d  = wt_cnt_q;
    mac_cnt_d = mac_cnt_q;
    acc_d     = acc_q;
    prod_d    = prod_q;
    out_d     = out_q;
`ifdef PE_SAT_EN
    sat_d     = sat_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = LOAD;
          len_d     = (cfg_len == '0 || cfg_len > DEPTH_L) ? DEPTH_L : cfg_len;
          keep_d    = wht_keep;
          if_cnt_d  = '0;
          wt_cnt_d  = '0;
          mac_cnt_d = '0;
          acc_d     = '0;
          prod_d    = '0;
`ifdef PE_SAT_EN
          sat_d     = 1'b0;
`endif
        end
      end
      LOAD: begin
        if (if_hs) if_cnt_d = if_cnt_q + 1'b1;
        if (wt_hs) wt_cnt_d = wt_cnt_q + 1'b1;
        if (if_cnt_d == len_q && (keep_q || wt_cnt_d == len_q)) state_d = MAC;
      end
      MAC: begin
        // Product of index i lands in acc one cycle later; cycle 0 only
        // primes the product register and cycle L only drains it.
        if (mac_cnt_q < len_q) prod_d = ACC_W'(mul_s);
        if (mac_cnt_q != '0) begin
          acc_d = add_res;
`ifdef PE_SAT_EN
          sat_d = sat_q | add_clip;
`endif
        end
        if (mac_cnt_q == len_q) state_d = PSUM;
        else                    mac_cnt_d = mac_cnt_q + 1'b1;
      end
      PSUM: begin
        if (ps_hs) begin
          acc_d   = add_res;
          out_d   = add_res;
          state_d = OUT;
`ifdef PE_SAT_EN
          sat_d   = sat_q | add_clip;
`endif
        end
      end
      OUT: begin
        if (out_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      len_q     <= '0;
      keep_q    <= 1'b0;
      if_cnt_q  <= '0;
      wt_cnt_q  <= '0;
      mac_cnt_q <= '0;
      acc_q     <= '0;
      prod_q    <= '0;
      out_q     <= '0;
`ifdef PE_SAT_EN
      sat_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      keep_q    <= keep_d;
      if_cnt_q  <= if_cnt_d;
      wt_cnt_q  <= wt_cnt_d;
      mac_cnt_q <= mac_cnt_d;
      acc_q     <= acc_d;
      prod_q    <= prod_d;
      out_q     <= out_d;
`ifdef PE_SAT_EN
      sat_q     <= sat_d;
`endif
    end
  end

endmodule

// File: tb/tb_pe_rs.sv
// Self-checking bench for pe_rs: directed passes plus randomized passes
// compared against a dot-product reference model.
// Honours PE_SAT_EN when the design is built with it.
module tb_pe_rs;

  localparam int LEN_W = 4;
  localparam int DEPTH = 12;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [LEN_W-1:0] cfg_len;
  logic             wht_keep;
  logic             if_vld;
  logic [7:0]       if_data;
  logic             if_rdy;
  logic             wht_vld;
  logic [7:0]       wht_data;
  logic             wht_rdy;
  logic             psum_vld;
  logic [31:0]      psum_in;
  logic             psum_rdy;
  logic             out_vld;
  logic [31:0]      out_data;
  logic             out_rdy;
  logic             busy;
`ifdef PE_SAT_EN
  logic             out_sat;
`endif

  pe_rs dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .cfg_len  (cfg_len),
    .wht_keep (wht_keep),
    .if_vld   (if_vld),
    .if_data  (if_data),
    .if_rdy   (if_rdy),
    .wht_vld  (wht_vld),
    .wht_data (wht_data),
    .wht_rdy  (wht_rdy),
    .psum_vld (psum_vld),
    .psum_in  (psum_in),
    .psum_rdy (psum_rdy),
    .out_vld  (out_vld),
    .out_data (out_data),
`ifdef PE_SAT_EN
    .out_sat  (out_sat),
`endif
    .out_rdy  (out_rdy),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference state: words to send this pass and the PE's resident weights.
  int cur_if [DEPTH];
  int cur_w  [DEPTH];
  int wres   [DEPTH];

  // Handshake/occupancy monitors.
  int n_if_hs = 0, n_wt_hs = 0, n_xfer = 0, n_vld = 0;
  bit saw_wrdy;

  always @(posedge clk) begin
    if (if_vld && if_rdy)   n_if_hs++;
    if (wht_vld && wht_rdy) n_wt_hs++;
    if (out_vld && out_rdy) n_xfer++;
    if (out_vld)            n_vld++;
    if (wht_rdy)            saw_wrdy = 1'b1;
  end

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else             n_pass++;
  endtask

  function automatic int eff_len(input int cfg);
    return (cfg == 0 || cfg > DEPTH) ? DEPTH : cfg;
  endfunction

  function automatic longint acc_step(input longint a, input longint x, inout bit clip);
    longint s;
    s = a + x;
`ifdef PE_SAT_EN
    if (s > 64'sd2147483647) begin
      s = 64'sd2147483647; clip = 1'b1;
    end else if (s < -64'sd2147483648) begin
      s = -64'sd2147483648; clip = 1'b1;
    end
`else
    s = longint'(int'(s));
`endif
    return s;
  endfunction

  // Dot product of ifmap and resident weights plus psum, one update per term.
  function automatic logic [31:0] model_pe(input int L, input int ps, output bit clip);
    longint acc;
    acc  = 0;
    clip = 1'b0;
    for (int i = 0; i < L; i++)
      acc = acc_step(acc, longint'(cur_if[i]) * longint'(wres[i]), clip);
    acc = acc_step(acc, longint'(ps), clip);
    return acc[31:0];
  endfunction

  task automatic drive_if(input int n, input int dly);
    bit taken;
    int budget;
    repeat (dly) @(negedge clk);
    for (int k = 0; k < n; k++) begin
      if_vld = 1'b1; if_data = 8'(cur_if[k]);
      taken = 1'b0; budget = 0;
      while (!taken && budget < 300) begin
        taken = if_rdy;
        @(negedge clk);
        budget++;
      end
      if (!taken) begin chk_eq("if_accept_timeout", 0, 1); break; end
      if ($urandom_range(3) == 0) begin
        if_vld = 1'b0; if_data = 8'($urandom);
        @(negedge clk);
      end
    end
    if_vld = 1'b0;
  endtask

  task automatic drive_wt(input int n, input int dly);
    bit taken;
    int budget;
    repeat (dly) @(negedge clk);
    for (int k = 0; k < n; k++) begin
      wht_vld = 1'b1; wht_data = 8'(cur_w[k]);
      taken = 1'b0; budget = 0;
      while (!taken && budget < 300) begin
        taken = wht_rdy;
        @(negedge clk);
        budget++;
      end
      if (!taken) begin chk_eq("wt_accept_timeout", 0, 1); break; end
      if ($urandom_range(3) == 0) begin
        wht_vld = 1'b0; wht_data = 8'($urandom);
        @(negedge clk);
      end
    end
    wht_vld = 1'b0;
  endtask

  // dly < 0: present psum immediately (ignored until PSUM); otherwise wait
  // for psum_rdy and then a further dly cycles.
  task automatic drive_ps(input int val, input int dly);
    bit taken;
    int budget;
    if (dly >= 0) begin
      budget = 0;
      while (!psum_rdy && budget < 400) begin @(negedge clk); budget++; end
      repeat (dly) @(negedge clk);
    end
    psum_vld = 1'b1; psum_in = val;
    taken = 1'b0; budget = 0;
    while (!taken && budget < 400) begin
      taken = psum_rdy;
      @(negedge clk);
      budget++;
    end
    if (!taken) chk_eq("psum_accept_timeout", 0, 1);
    psum_vld = 1'b0; psum_in = $urandom;
  endtask

  task automatic run_pass(input int cfg, input bit keep, input int ifd, input int wtd,
                          input int psd, input int ps, input int hold);
    int L, if0, wt0, x0, v0, budget;
    bit exp_clip;
    logic [31:0] exp;
    L = eff_len(cfg);
    if (!keep) for (int i = 0; i < L; i++) wres[i] = cur_w[i];
    exp = model_pe(L, ps, exp_clip);
    if0 = n_if_hs; wt0 = n_wt_hs; x0 = n_xfer; v0 = n_vld;
    @(negedge clk);
    start = 1'b1; cfg_len = LEN_W'(cfg); wht_keep = keep; saw_wrdy = 1'b0;
    @(negedge clk);
    chk_eq("busy_after_start", busy, 1);
    // start stays high and config churns while busy: must be ignored.
    cfg_len = LEN_W'($urandom); wht_keep = ~keep;
    if (keep) begin wht_vld = 1'b1; wht_data = 8'($urandom); end
    fork
      drive_if(L, ifd);
      if (!keep) drive_wt(L, wtd);
      drive_ps(ps, psd);
    join
    start = 1'b0; wht_vld = 1'b0;
    budget = 0;
    while (!out_vld && budget < 100) begin @(negedge clk); budget++; end
    chk_eq("out_vld_seen", out_vld, 1);
    chk_eq("out_data", out_data, exp);
`ifdef PE_SAT_EN
    chk_eq("out_sat", out_sat, exp_clip);
`endif
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk_eq("hold_vld", out_vld, 1);
      chk_eq("hold_data", out_data, exp);
    end
    out_rdy = 1'b1;
    @(negedge clk);
    out_rdy = 1'b0;
    chk_eq("vld_after_xfer", out_vld, 0);
    chk_eq("busy_after_xfer", busy, 0);
    chk_eq("xfer_count", n_xfer - x0, 1);
    chk_eq("vld_cycles", n_vld - v0, hold + 1);
    chk_eq("if_words", n_if_hs - if0, L);
    chk_eq("wt_words", n_wt_hs - wt0, keep ? 0 : L);
    if (keep) chk_eq("wrdy_keep", saw_wrdy, 0);
  endtask

  task automatic set_row(input int idx, input int a, input int b);
    cur_if[idx] = a; cur_w[idx] = b;
  endtask

  task automatic rand_rows();
    for (int i = 0; i < DEPTH; i++) begin
      cur_if[i] = int'($urandom_range(255)) - 128;
      cur_w[i]  = int'($urandom_range(255)) - 128;
    end
  endtask

  initial begin
    int cfg;
    rst_n = 1'b0; start = 1'b0; cfg_len = '0; wht_keep = 1'b0;
    if_vld = 1'b0; if_data = '0; wht_vld = 1'b0; wht_data = '0;
    psum_vld = 1'b0; psum_in = '0; out_rdy = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin cur_if[i] = 0; cur_w[i] = 0; wres[i] = 0; end
    #1;
    chk_eq("rst_if_rdy", if_rdy, 0);
    chk_eq("rst_wht_rdy", wht_rdy, 0);
    chk_eq("rst_psum_rdy", psum_rdy, 0);
    chk_eq("rst_out_vld", out_vld, 0);
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_out_data", out_data, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Basic dot product: 4+10+18+10.
    set_row(0, 1, 4); set_row(1, 2, 5); set_row(2, 3, 6);
    run_pass(3, 1'b0, 0, 0, -1, 10, 0);
    // Reuse resident weights {4,5,6}.
    set_row(0, 1, 99); set_row(1, 1, 99); set_row(2, 1, 99);
    run_pass(3, 1'b1, 0, 0, 0, 0, 0);
    // Signed operands.
    set_row(0, -2, 7); set_row(1, 3, -4);
    run_pass(2, 1'b0, 0, 0, 1, -1, 1);
    // cfg_len=0 selects the full depth; output held off for 5 cycles.
    rand_rows();
    run_pass(0, 1'b0, 0, 0, 0, 32'h1234, 5);
    // Weights late by 4, psum late by 3.
    rand_rows();
    run_pass(3, 1'b0, 0, 4, 3, 77, 0);

    // Randomized passes, including over-range cfg_len and weight reuse.
    for (int t = 0; t < 20; t++) begin
      rand_rows();
      cfg = int'($urandom_range(15));
      run_pass(cfg, ($urandom_range(3) == 0), int'($urandom_range(4)), int'($urandom_range(4)),
               int'($urandom_range(4)) - 1, int'($urandom), int'($urandom_range(3)));
    end

    // Reset during MAC: immediate idle, no output, RFs cleared.
    rand_rows();
    @(negedge clk);
    start = 1'b1; cfg_len = '0; wht_keep = 1'b0;
    @(negedge clk);
    start = 1'b0;
    fork
      drive_if(DEPTH, 0);
      drive_wt(DEPTH, 0);
    join
    repeat (3) @(negedge clk);
    chk_eq("busy_in_mac", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk_eq("midrst_busy", busy, 0);
    chk_eq("midrst_out_vld", out_vld, 0);
    chk_eq("midrst_psum_rdy", psum_rdy, 0);
    chk_eq("midrst_out_data", out_data, 0);
    for (int i = 0; i < DEPTH; i++) wres[i] = 0;
    @(negedge clk);
    rst_n = 1'b1;
    // Weight reuse after reset sees cleared weights: result is psum alone.
    set_row(0, 5, 0); set_row(1, 6, 0); set_row(2, 7, 0);
    run_pass(3, 1'b1, 0, 0, 0, 321, 0);
    rand_rows();
    run_pass(5, 1'b0, 1, 0, 0, -5000, 1);

`ifdef PE_SAT_EN
    // 16*16 = 0x100 plus 0x7FFFFFF0 clips to the positive limit.
    set_row(0, 16, 16);
    run_pass(1, 1'b0, 0, 0, 0, 32'h7FFFFFF0, 0);
    chk_eq("sat_value", out_data, 32'h7FFFFFFF);
    set_row(0, -128, 127);
    run_pass(1, 1'b0, 0, 0, 0, 32'h80000000, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Global watchdog so the bench always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
